// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI SRAM wrapper burst scheduler.
package axi_sram_pkg;

  // Widest start address the active-burst register can hold.
  localparam int unsigned SCHED_ADDR_W = 64;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } sched_state_t;

  typedef struct packed {
    logic [SCHED_ADDR_W-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } burst_req_t;

endpackage

// File: rtl/axi_sram_beat_addr_gen.sv
// Combinational per-beat byte address for an AXI burst (FIXED/INCR/WRAP).
// WRAP with a len other than 1/3/7/15, and the reserved burst type, step as INCR.
module axi_sram_beat_addr_gen
  import axi_sram_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64
) (
  input  logic [AXI_ADDR_WIDTH-1:0] start,
  input  logic [7:0]                len,
  input  logic [2:0]                size,
  input  logic [1:0]                burst,
  input  logic [7:0]                count,
  output logic [AXI_ADDR_WIDTH-1:0] addr
);

  logic [AXI_ADDR_WIDTH-1:0] beat_mask;
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
  logic [AXI_ADDR_WIDTH-1:0] offset;
  logic                      wrap_ok;

  // Select the address form for the burst type from the beat offset n*B.
  always_comb begin
    beat_mask = (AXI_ADDR_WIDTH'(1) << size) - AXI_ADDR_WIDTH'(1);
    wrap_mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
    offset    = AXI_ADDR_WIDTH'(count) << size;
    wrap_ok   = (burst == BURST_WRAP) &&
                ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    if (burst == BURST_FIXED) begin
      addr = start;
    end else if (wrap_ok) begin
      addr = (start & ~wrap_mask) | ((start + offset) & wrap_mask);
    end else begin
      addr = (start & ~beat_mask) + offset;
    end
  end

endmodule

// File: rtl/axi_sram_rw_sched.sv
// Shares the single SRAM bank port between the read and write request queues,
// granting whole bursts and issuing one beat per cycle.
// Optional macro AXI_SRAM_SCHED_RD_PRIO_EN: read priority with a write starve limit;
// undefined gives strict burst-level round-robin.
module axi_sram_rw_sched
  import axi_sram_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 64,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned WR_STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [7:0]                rd_req_len,
  input  logic [2:0]                rd_req_size,
  input  logic [1:0]                rd_req_burst,
  input  logic                      wr_req_valid,
  output logic                      wr_req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [7:0]                wr_req_len,
  input  logic [2:0]                wr_req_size,
  input  logic [1:0]                wr_req_burst,
  input  logic                      wdata_valid,
  input  logic                      rd_credit,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic                      beat_write,
  output logic [AXI_ADDR_WIDTH-1:0] beat_addr,
  output logic                      beat_last,
  output logic                      wdata_pop,
  output logic                      busy
);

  sched_state_t state, state_next;
  burst_req_t   act, req_sel;
  logic [7:0]   cnt;
  logic         last_was_write;
  logic         grant_pt, pick_rd, pick_wr, beat_hs, write_first;
  logic         unused_cfg;

`ifdef AXI_SRAM_SCHED_RD_PRIO_EN
  localparam int unsigned STARVE_W = $clog2(WR_STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve;

  // Reads win contention until writes have been passed over the limit.
  always_comb write_first = (starve >= STARVE_W'(WR_STARVE_LIMIT));

  // Saturating count of consecutive read grants made while a write waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve <= '0;
    end else if (grant_pt && pick_wr) begin
      starve <= '0;
    end else if (grant_pt && pick_rd) begin
      if (!wr_req_valid) starve <= '0;
      else if (!write_first) starve <= starve + 1'b1;
    end
  end

  // Configuration inputs with no logic in this build.
  always_comb unused_cfg = last_was_write ^ (AXI_DATA_WIDTH == 0);
`else
  // Strict round-robin: contended grant goes to the type not granted last.
  always_comb write_first = !last_was_write;

  // Configuration inputs with no logic in this build.
  always_comb unused_cfg = (WR_STARVE_LIMIT == 0) ^ (AXI_DATA_WIDTH == 0);
`endif

  // Beat gating, arbitration at grant points, and next-state selection.
  always_comb begin
    beat_valid = 1'b0;
    case (state)
      RD:      beat_valid = rd_credit;
      WR:      beat_valid = wdata_valid;
      default: beat_valid = 1'b0;
    endcase
    if (reset) beat_valid = 1'b0;
    busy       = (state != IDLE);
    beat_write = (state == WR);
    beat_last  = busy && (cnt == act.len);
    beat_hs    = beat_valid && beat_ready;
    wdata_pop  = beat_hs && beat_write;
    // Reset blocks grants so a queue head is never popped into a discarded burst.
    grant_pt     = !reset && ((state == IDLE) || (beat_hs && beat_last));
    pick_wr      = wr_req_valid && (!rd_req_valid || write_first);
    pick_rd      = rd_req_valid && !pick_wr;
    rd_req_ready = grant_pt && pick_rd;
    wr_req_ready = grant_pt && pick_wr;
    req_sel.addr  = pick_wr ? SCHED_ADDR_W'(wr_req_addr) : SCHED_ADDR_W'(rd_req_addr);
    req_sel.len   = pick_wr ? wr_req_len   : rd_req_len;
    req_sel.size  = pick_wr ? wr_req_size  : rd_req_size;
    req_sel.burst = pick_wr ? wr_req_burst : rd_req_burst;
    state_next = state;
    if (grant_pt) begin
      if (pick_rd)      state_next = RD;
      else if (pick_wr) state_next = WR;
      else              state_next = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Active burst registers, beat counter and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      act            <= '0;
      cnt            <= '0;
      last_was_write <= 1'b1;
    end else if (grant_pt && (pick_rd || pick_wr)) begin
      act            <= req_sel;
      cnt            <= '0;
      last_was_write <= pick_wr;
    end else if (beat_hs) begin
      cnt <= cnt + 8'd1;
    end
  end

  axi_sram_beat_addr_gen #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_addr_gen (
    .start (act.addr[AXI_ADDR_WIDTH-1:0]),
    .len   (act.len),
    .size  (act.size),
    .burst (act.burst),
    .count (cnt),
    .addr  (beat_addr)
  );

endmodule

// File: tb/tb_axi_sram_rw_sched.sv
// Scoreboard bench for axi_sram_rw_sched: expected beats are queued per request
// type when a request is offered and consumed as beats hand off.
module tb_axi_sram_rw_sched;
  import axi_sram_pkg::*;

  typedef struct packed {
    logic [63:0] addr;
    logic        last;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        rd_req_valid, rd_req_ready, wr_req_valid, wr_req_ready;
  logic [63:0] rd_req_addr, wr_req_addr;
  logic [7:0]  rd_req_len, wr_req_len;
  logic [2:0]  rd_req_size, wr_req_size;
  logic [1:0]  rd_req_burst, wr_req_burst;
  logic        wdata_valid, rd_credit, beat_valid, beat_ready, beat_write, beat_last;
  logic [63:0] beat_addr;
  logic        wdata_pop, busy;

  logic t_reset, t_wdv, t_credit, t_bready;
  logic take_rd, take_wr;
  burst_req_t rq[$];
  burst_req_t wq[$];
  beat_t exp_rd_q[$];
  beat_t exp_wr_q[$];
  bit    glog[$];
  int    n_checks, n_pass, cyc, first_beat, last_beat, nbeats, npop;

  axi_sram_rw_sched #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .WR_STARVE_LIMIT(2)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_req_size(rd_req_size), .rd_req_burst(rd_req_burst),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
    .wr_req_size(wr_req_size), .wr_req_burst(wr_req_burst),
    .wdata_valid(wdata_valid), .rd_credit(rd_credit),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_write(beat_write),
    .beat_addr(beat_addr), .beat_last(beat_last),
    .wdata_pop(wdata_pop), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Queue a request and its expected beats (address stepped beat by beat).
  task automatic push_req(input bit wr, input logic [63:0] addr, input int len,
                          input int size, input int burst);
    burst_req_t r;
    beat_t      b;
    logic [63:0] bs, w, lo, a;
    bit          wrap_ok;
    r.addr = addr; r.len = 8'(len); r.size = 3'(size); r.burst = 2'(burst);
    bs = 64'd1 << size;
    w  = bs * 64'(len + 1);
    wrap_ok = (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
    lo = addr - (addr % w);
    a  = (burst == 0 || wrap_ok) ? addr : addr - (addr % bs);
    for (int n = 0; n <= len; n++) begin
      b.addr = a; b.last = (n == len);
      if (wr) exp_wr_q.push_back(b); else exp_rd_q.push_back(b);
      if (burst != 0) begin
        a = a + bs;
        if (wrap_ok && a >= lo + w) a = a - w;
      end
    end
    if (wr) wq.push_back(r); else rq.push_back(r);
  endtask

  // One cycle: drive inputs after the edge, observe at the falling edge.
  task automatic tick();
    beat_t e;
    @(posedge clk); #1;
    if (take_rd) void'(rq.pop_front());
    if (take_wr) void'(wq.pop_front());
    reset = t_reset; wdata_valid = t_wdv; rd_credit = t_credit; beat_ready = t_bready;
    rd_req_valid = (rq.size() != 0);
    wr_req_valid = (wq.size() != 0);
    if (rd_req_valid) begin
      rd_req_addr = rq[0].addr; rd_req_len = rq[0].len;
      rd_req_size = rq[0].size; rd_req_burst = rq[0].burst;
    end else begin
      rd_req_addr = '0; rd_req_len = '0; rd_req_size = '0; rd_req_burst = '0;
    end
    if (wr_req_valid) begin
      wr_req_addr = wq[0].addr; wr_req_len = wq[0].len;
      wr_req_size = wq[0].size; wr_req_burst = wq[0].burst;
    end else begin
      wr_req_addr = '0; wr_req_len = '0; wr_req_size = '0; wr_req_burst = '0;
    end
    @(negedge clk);
    cyc++;
    take_rd = rd_req_ready;
    take_wr = wr_req_ready;
    if (rd_req_ready) glog.push_back(1'b0);
    if (wr_req_ready) glog.push_back(1'b1);
    if (wdata_pop) npop++;
    if (beat_valid && beat_ready) begin
      if (beat_write ? exp_wr_q.size() == 0 : exp_rd_q.size() == 0) begin
        check("beat_expected", beat_write ? exp_wr_q.size() : exp_rd_q.size(), 1);
      end else begin
        e = beat_write ? exp_wr_q.pop_front() : exp_rd_q.pop_front();
        check(beat_write ? "wr_beat_addr" : "rd_beat_addr", beat_addr, e.addr);
        check(beat_write ? "wr_beat_last" : "rd_beat_last", beat_last, e.last);
      end
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      nbeats++;
    end
  endtask

  task automatic run_until_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (rq.size() == 0 && wq.size() == 0 && exp_rd_q.size() == 0 &&
          exp_wr_q.size() == 0 && !busy) break;
      tick();
    end
    check("drain_rd", exp_rd_q.size(), 0);
    check("drain_wr", exp_wr_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    t_reset = 1'b1; tick(); tick();
    t_reset = 1'b0;
  endtask

  initial begin
    bit exp_order[6];
    int k;
    logic [63:0] exp_addr;
    bit pat[5];
    n_checks = 0; n_pass = 0; cyc = 0; first_beat = -1; last_beat = 0; nbeats = 0; npop = 0;
    take_rd = 0; take_wr = 0;
    t_reset = 1'b1; t_wdv = 1'b1; t_credit = 1'b1; t_bready = 1'b1;

    // Reset values
    tick(); tick();
    check("rst_beat_valid", beat_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_beat_addr", beat_addr, 0);
    check("rst_beat_last", beat_last, 0);
    check("rst_beat_write", beat_write, 0);
    check("rst_wdata_pop", wdata_pop, 0);
    t_reset = 1'b0;
    tick();
    check("idle_rd_ready", rd_req_ready, 0);
    check("idle_wr_ready", wr_req_ready, 0);

    // Single INCR read: grant in cycle 0, four beats, busy drops in cycle 5
    push_req(0, 64'h100, 3, 3, 1);
    tick();
    check("t1_rd_ready", rd_req_ready, 1);
    check("t1_c0_valid", beat_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t1_valid", beat_valid, 1);
      check("t1_last", beat_last, (i == 4));
      check("t1_busy", busy, 1);
    end
    tick();
    check("t1_busy_drop", busy, 0);
    check("t1_drained", exp_rd_q.size(), 0);

    // Burst types: WRAP, FIXED, illegal-len WRAP, reserved, small WRAP, unaligned INCR
    push_req(0, 64'h38, 3, 3, 2);
    push_req(0, 64'h40, 2, 3, 0);
    push_req(0, 64'h38, 2, 3, 2);
    push_req(0, 64'h104, 1, 2, 3);
    push_req(0, 64'h1C, 1, 2, 2);
    push_req(0, 64'h103, 1, 2, 1);
    run_until_idle(100);

    // Both queues continuously pending: grant order and zero bubbles
    do_reset();
    glog.delete(); first_beat = -1; nbeats = 0;
`ifdef AXI_SRAM_SCHED_RD_PRIO_EN
    for (int i = 0; i < 4; i++) push_req(0, 64'h1000 + 64'(i * 16), 1, 3, 1);
    for (int i = 0; i < 2; i++) push_req(1, 64'h2000 + 64'(i * 16), 1, 3, 1);
    exp_order = '{0, 0, 1, 0, 0, 1};
`else
    for (int i = 0; i < 3; i++) push_req(0, 64'h1000 + 64'(i * 16), 1, 3, 1);
    for (int i = 0; i < 3; i++) push_req(1, 64'h2000 + 64'(i * 16), 1, 3, 1);
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    run_until_idle(200);
    check("grant_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size()) check($sformatf("grant_%0d_is_wr", i), glog[i], exp_order[i]);
    end
    check("b2b_beats", nbeats, 12);
    check("b2b_span", last_beat - first_beat + 1, 12);

    // Write throttled by wdata_valid; address holds during stalls
    npop = 0;
    t_wdv = 1'b0;
    push_req(1, 64'h200, 2, 2, 1);
    tick();
    check("t4_wr_ready", wr_req_ready, 1);
    pat = '{1, 0, 1, 0, 1};
    k = 0;
    for (int i = 0; i < 5; i++) begin
      t_wdv = pat[i];
      tick();
      exp_addr = 64'h200 + 64'(4 * k);
      check("t4_valid", beat_valid, pat[i]);
      check("t4_addr", beat_addr, exp_addr);
      if (pat[i]) k++;
    end
    t_wdv = 1'b1;
    tick();
    check("t4_pops", npop, 3);
    check("t4_busy", busy, 0);

    // beat_ready stall and rd_credit gating on a single-beat read
    t_bready = 1'b0;
    push_req(0, 64'h300, 0, 3, 1);
    tick();
    check("t5_rd_ready", rd_req_ready, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t5_stall_valid", beat_valid, 1);
      check("t5_stall_addr", beat_addr, 64'h300);
      check("t5_stall_last", beat_last, 1);
    end
    t_credit = 1'b0;
    tick();
    check("t5_no_credit", beat_valid, 0);
    t_credit = 1'b1; t_bready = 1'b1;
    tick();
    tick();
    check("t5_busy", busy, 0);
    check("t5_drained", exp_rd_q.size(), 0);

    // Reset on beat 1 of a len-7 read, then a fresh burst from beat 0
    push_req(0, 64'h400, 7, 3, 1);
    tick();
    tick();
    t_reset = 1'b1;
    tick();
    exp_rd_q.delete();
    t_reset = 1'b0;
    tick();
    check("t6_valid_after_rst", beat_valid, 0);
    check("t6_busy_after_rst", busy, 0);
    push_req(0, 64'h500, 1, 3, 1);
    tick();
    check("t6_rd_ready", rd_req_ready, 1);
    tick();
    check("t6_beat0_valid", beat_valid, 1);
    check("t6_beat0_addr", beat_addr, 64'h500);
    run_until_idle(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_sram_rw_sched.md
# axi_sram_rw_sched

Burst scheduler that shares the single SRAM bank port of the AXI SRAM wrapper between its read-request queue and its write-request queue. It grants whole AXI bursts, expands each granted burst into per-beat SRAM addresses (FIXED/INCR/WRAP), and presents one beat per cycle to the bank address decoder. Write beats are throttled by write-data availability and read beats by read-response buffer credit.

## Interface
- AXI_ADDR_WIDTH, 64: byte address width.
- AXI_DATA_WIDTH, 64: data width; the maximum legal size is $clog2(AXI_DATA_WIDTH/8).
- WR_STARVE_LIMIT, 4: maximum consecutive read bursts granted while a write waits. Used only with the macro.
- clk  in  1: clock.
- reset  in  1: synchronous, active-high reset.
- rd_req_valid / wr_req_valid  in  1: head of the read / write request queue is valid.
- rd_req_ready / wr_req_ready  out  1: burst accepted (pop the queue head).
- rd_req_addr / wr_req_addr  in  AXI_ADDR_WIDTH: burst start address.
- rd_req_len / wr_req_len  in  8: burst length minus 1.
- rd_req_size / wr_req_size  in  3: log2 of bytes per beat.
- rd_req_burst / wr_req_burst  in  2: burst type. 0 = FIXED, 1 = INCR, 2 = WRAP.
- wdata_valid  in  1: write-data FIFO is non-empty.
- rd_credit  in  1: the read ID/data buffers can accept one more beat.
- beat_valid  out  1: an SRAM beat is presented.
- beat_ready  in  1: the decoder accepts the beat.
- beat_write  out  1: 1 = write beat, 0 = read beat.
- beat_addr  out  AXI_ADDR_WIDTH: byte address of the current beat.
- beat_last  out  1: current beat is the final beat of its burst.
- wdata_pop  out  1: pop the write-data FIFO. Equals beat handshake AND beat_write.
- busy  out  1: state is not IDLE.

## Operation
- FSM states:
  - IDLE: no active burst.
  - RD: a read burst is active.
  - WR: a write burst is active.
- A grant point is any cycle where the state is IDLE, or where the last beat of the active burst completes its handshake.
  - At a grant point, the arbiter picks at most one pending request.
  - It asserts the matching *_req_ready for that same cycle.
  - It loads start address, len, size, burst and a zeroed beat counter into the active registers.
  - Next state is RD or WR. If nothing is pending, next state is IDLE.
- Beat gating:
  - In RD: beat_valid = rd_credit.
  - In WR: beat_valid = wdata_valid.
  - In IDLE: beat_valid = 0.
- Each beat handshake increments the 8-bit beat counter.
- beat_last = (counter == len).
- Beat address, with n = counter and B = 1 << size:
  - FIXED: start address.
  - INCR: (start & ~(B-1)) + n·B, truncated to AXI_ADDR_WIDTH.
  - WRAP: wrap boundary W = (len+1)·B. Address is (start & ~(W-1)) | ((start + n·B) & (W-1)). Legal len for WRAP is 1, 3, 7 or 15. Any other len is treated as INCR.
  - Burst type 3 (reserved) is treated as INCR.
- Default arbitration is round-robin at burst granularity.
  - A last_was_write flag updates on every grant.
  - When both requests are pending, the type not granted last wins.
  - When only one request is pending, it wins.
- Simultaneous events:
  - A last-beat handshake and a new grant in the same cycle give back-to-back bursts with zero bubble.
  - A request that becomes valid on the same cycle as a grant point is eligible at that grant point.
- Reset during a burst: the active burst is discarded and no further beats are issued. Queue contents are owned upstream.

## Timing
- Reset values: state = IDLE, last_was_write = 1 (so the first contended grant goes to read), counter = 0, starve count = 0.
- Output reset values: beat_valid, beat_write, beat_last, rd_req_ready, wr_req_ready, wdata_pop and busy are all 0. beat_addr is 0.
- From IDLE with a request valid: *_req_ready is asserted in cycle T, and beat 0 is valid in T+1 (subject to gating).
- *_req_ready, beat_* and wdata_pop are combinational from registered state plus gating inputs. No combinational path runs from beat_ready to beat_valid.
- A single-beat burst holds the port for 1 cycle. A back-to-back burst sequence sustains 1 beat per cycle.
- beat_addr, beat_write and beat_last stay stable while beat_valid = 1 and beat_ready = 0.

## Configuration
- AXI_SRAM_SCHED_RD_PRIO_EN defined: reads have priority.
  - A saturating starve counter counts consecutive read grants made while wr_req_valid = 1.
  - When the counter reaches WR_STARVE_LIMIT, the next contended grant goes to write and the counter clears.
  - The counter also clears on any write grant.
- Macro undefined: strict round-robin as described in Operation. The starve counter and WR_STARVE_LIMIT are unused and not synthesized.

## Structure
- The axi_sram_pkg package holds:
  - the sched_state_t enum {IDLE, RD, WR};
  - the burst_req_t packed struct (addr, len, size, burst);
  - the BURST_FIXED, BURST_INCR and BURST_WRAP constants.
- Sub-module axi_sram_beat_addr_gen: combinational start/len/size/burst/count to beat_addr. It is reusable by the response path.

## Test plan
- Single read, addr 0x100, len 3, INCR, size 3, rd_credit = 1 → rd_req_ready in cycle 0, then beats 0x100/0x108/0x110/0x118 in cycles 1–4, beat_last only on 0x118, busy drops in cycle 5.
- WRAP, addr 0x38, len 3, size 3 → addresses 0x38, 0x20, 0x28, 0x30.
- Reads and writes both continuously pending, macro off → bursts alternate R, W, R, W, the first is R, and there are no idle cycles between last beat and next beat 0.
- Macro on, WR_STARVE_LIMIT = 2, both continuously pending → grant order R, R, W, R, R, W.
- Write burst len 2 with wdata_valid toggling 1,0,1,0,1 → beats issue only when wdata_valid = 1, wdata_pop pulses 3 times, and beat_addr holds steady during stalls.
- Reset asserted on beat 1 of a len-7 read → the next cycle has beat_valid = 0, state IDLE and busy = 0. A new request after reset starts at beat 0.
